// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared register-file constants, types and helpers
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package wb_port_arbiter_pkg;

    localparam int WORD_SIZE  = `WORD_SIZE;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]   busy_vec_t;

    // One-hot scoreboard mask for a register index.
    function automatic busy_vec_t reg_onehot(input reg_addr_t r);
        return busy_vec_t'(1) << r;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - write-back request, register-file and scoreboard bundle
// Ports:
//   req_valid/req_reg/req_data/req_ready : NREQ write-back sources, flat slices per requester
//   rf_write_enable/rf_write_reg/rf_write_data : registered register-file write port
//   rsv_valid/rsv_reg/rsv_ok : destination reservation from issue logic
//   chk_reg1/chk_reg2/chk_busy1/chk_busy2 : hazard lookup, busy : full scoreboard
// Modports: slave = arbiter side, master = surrounding pipeline side.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = WORD_SIZE
) ();

    logic [NREQ-1:0]            req_valid;
    logic [REG_ADDR_W*NREQ-1:0] req_reg;
    logic [DATA_W*NREQ-1:0]     req_data;
    logic [NREQ-1:0]            req_ready;

    logic                       rf_write_enable;
    reg_addr_t                  rf_write_reg;
    logic [DATA_W-1:0]          rf_write_data;

    logic                       rsv_valid;
    reg_addr_t                  rsv_reg;
    logic                       rsv_ok;

    reg_addr_t                  chk_reg1;
    reg_addr_t                  chk_reg2;
    logic                       chk_busy1;
    logic                       chk_busy2;
    busy_vec_t                  busy;

    modport slave (
        input  req_valid, req_reg, req_data, rsv_valid, rsv_reg, chk_reg1, chk_reg2,
        output req_ready, rf_write_enable, rf_write_reg, rf_write_data,
               rsv_ok, chk_busy1, chk_busy2, busy
    );

    modport master (
        output req_valid, req_reg, req_data, rsv_valid, rsv_reg, chk_reg1, chk_reg2,
        input  req_ready, rf_write_enable, rf_write_reg, rf_write_data,
               rsv_ok, chk_busy1, chk_busy2, busy
    );

endinterface

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// rtl/wb_port_arbiter_rr_arbiter.sv - round-robin arbiter with internal priority pointer
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   req      : N request lines
//   advance  : a grant was consumed this cycle; pointer moves past the winner
//   grant    : combinational one-hot grant, zero when no request
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    int            idx;

    // Scan from the farthest position back toward ptr so the closest
    // requester at or after ptr is the last (winning) assignment.
    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        idx      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx[PW-1:0]]) begin
                grant              = '0;
                grant[idx[PW-1:0]] = 1'b1;
                ptr_next           = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-back arbiter with busy scoreboard
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wb_port_arbiter_if slave modport carrying requesters, the registered
//              register-file write port, reservation and hazard-check signals
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = WORD_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    logic [NREQ-1:0]   grant;
    logic              xfer;
    reg_addr_t         xfer_reg;
    logic [DATA_W-1:0] xfer_data;

    logic              we_q;
    reg_addr_t         wreg_q;
    logic [DATA_W-1:0] wdata_q;

    busy_vec_t         busy_q;
    busy_vec_t         set_vec;
    busy_vec_t         clr_vec;
    logic              rsv_ok;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (xfer),
        .grant   (grant)
    );

    assign bus.req_ready = grant;
    assign xfer          = |(bus.req_valid & grant);

    always_comb begin
        xfer_reg  = '0;
        xfer_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                xfer_reg  = bus.req_reg[i*REG_ADDR_W +: REG_ADDR_W];
                xfer_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // r0 writes still consume the grant but never strobe the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= xfer && (xfer_reg != '0);
            if (xfer) begin
                wreg_q  <= xfer_reg;
                wdata_q <= xfer_data;
            end
        end
    end

    assign bus.rf_write_enable = we_q;
    assign bus.rf_write_reg    = wreg_q;
    assign bus.rf_write_data   = wdata_q;

    // Reservation is judged on the pre-edge busy bit, so a reserve that
    // collides with the committing write of the same register is rejected.
    assign rsv_ok  = bus.rsv_valid & ((bus.rsv_reg == '0) | ~busy_q[bus.rsv_reg]);
    assign set_vec = (rsv_ok && (bus.rsv_reg != '0)) ? reg_onehot(bus.rsv_reg) : '0;
    assign clr_vec = we_q ? reg_onehot(wreg_q) : '0;

    // Set is applied after clear: a fresh reservation accepted while an
    // unreserved write to the same register commits belongs to a later write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~clr_vec) | set_vec) & ~busy_vec_t'(1);
        end
    end

    assign bus.rsv_ok    = rsv_ok;
    assign bus.busy      = busy_q;
    assign bus.chk_busy1 = busy_q[bus.chk_reg1];
    assign bus.chk_busy2 = busy_q[bus.chk_reg2];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - table-driven self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cur;

    wb_port_arbiter_if #(.NREQ(3), .DATA_W(32)) bus ();

    wb_port_arbiter #(.NREQ(3), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  vld;
        logic [14:0] regs;
        logic [95:0] data;
        logic        rv;
        logic [4:0]  rr;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic [2:0]  rdy;
        logic        ok;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] busy;
        logic        cb1;
        logic        cb2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [2:0] vld, input logic [14:0] regs,
                       input logic [95:0] data, input logic rv, input logic [4:0] rr,
                       input logic [4:0] c1, input logic [4:0] c2, input logic [2:0] rdy,
                       input logic ok, input logic we, input logic [4:0] wreg,
                       input logic [31:0] wdata, input logic [31:0] busy,
                       input logic cb1, input logic cb2);
        vec_t v;
        v.rst = r; v.vld = vld; v.regs = regs; v.data = data; v.rv = rv; v.rr = rr;
        v.c1 = c1; v.c2 = c2; v.rdy = rdy; v.ok = ok; v.we = we; v.wreg = wreg;
        v.wdata = wdata; v.busy = busy; v.cb1 = cb1; v.cb2 = cb2;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", nm, cur, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.req_valid = '0;
        bus.req_reg   = '0;
        bus.req_data  = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_reg   = '0;
        bus.chk_reg1  = 5'd5;
        bus.chk_reg2  = 5'd7;
    endtask

    localparam logic [14:0] RR_REGS = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] RR_DATA = {32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};

    initial begin
        checks   = 0;
        failures = 0;
        cur      = -1;
        rst      = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_we",   32'(bus.rf_write_enable), 32'd0);
        check("reset_busy", bus.busy, 32'd0);
        check("reset_rdy",  32'(bus.req_ready), 32'd0);
        rst = 1'b0;

        //   rst vld     regs                    data                                   rv rr  c1 c2 rdy    ok we wreg wdata          busy    cb1 cb2
        add(0, 3'b000, 15'd0, 96'd0,                                                    0, 0,  5, 7, 3'b000, 0, 0, 0, 32'h0,        32'h00, 0, 0);
        add(0, 3'b000, 15'd0, 96'd0,                                                    1, 5,  5, 7, 3'b000, 1, 0, 0, 32'h0,        32'h00, 0, 0);
        add(0, 3'b010, {5'd0,5'd5,5'd0}, {32'h0,32'hDEADBEEF,32'h0},                    0, 0,  5, 7, 3'b010, 0, 0, 0, 32'h0,        32'h20, 1, 0);
        add(0, 3'b000, 15'd0, 96'd0,                                                    0, 0,  5, 7, 3'b000, 0, 1, 5, 32'hDEADBEEF, 32'h20, 1, 0);
        add(0, 3'b000, 15'd0, 96'd0,                                                    0, 0,  5, 7, 3'b000, 0, 0, 0, 32'h0,        32'h00, 0, 0);
        add(1, 3'b110, RR_REGS, RR_DATA,                                                0, 0,  5, 7, 3'b010, 0, 0, 0, 32'h0,        32'h00, 0, 0);
        add(0, 3'b111, RR_REGS, RR_DATA,                                                0, 0,  5, 7, 3'b001, 0, 0, 0, 32'h0,        32'h00, 0, 0);
        add(0, 3'b111, RR_REGS, RR_DATA,                                                0, 0,  5, 7, 3'b010, 0, 1, 1, 32'hA0A0A0A0, 32'h00, 0, 0);
        add(0, 3'b111, RR_REGS, RR_DATA,                                                0, 0,  5, 7, 3'b100, 0, 1, 2, 32'hA1A1A1A1, 32'h00, 0, 0);
        add(0, 3'b111, RR_REGS, RR_DATA,                                                0, 0,  5, 7, 3'b001, 0, 1, 3, 32'hA2A2A2A2, 32'h00, 0, 0);
        add(0, 3'b111, RR_REGS, RR_DATA,                                                0, 0,  5, 7, 3'b010, 0, 1, 1, 32'hA0A0A0A0, 32'h00, 0, 0);
        add(0, 3'b111, RR_REGS, RR_DATA,                                                0, 0,  5, 7, 3'b100, 0, 1, 2, 32'hA1A1A1A1, 32'h00, 0, 0);
        add(0, 3'b000, 15'd0, 96'd0,                                                    0, 0,  5, 7, 3'b000, 0, 1, 3, 32'hA2A2A2A2, 32'h00, 0, 0);
        add(0, 3'b001, 15'd0, {32'h0,32'h0,32'h1234},                                   0, 0,  5, 7, 3'b001, 0, 0, 0, 32'h0,        32'h00, 0, 0);
        add(0, 3'b000, 15'd0, 96'd0,                                                    0, 0,  5, 7, 3'b000, 0, 0, 0, 32'h0,        32'h00, 0, 0);
        add(0, 3'b101, {5'd11,5'd0,5'd10}, {32'hB2,32'h0,32'hB0},                       0, 0,  5, 7, 3'b100, 0, 0, 0, 32'h0,        32'h00, 0, 0);
        add(0, 3'b011, {5'd0,5'd12,5'd10}, {32'h0,32'hB1,32'hB0},                       0, 0,  5, 7, 3'b001, 0, 1, 11, 32'hB2,      32'h00, 0, 0);
        add(0, 3'b000, 15'd0, 96'd0,                                                    0, 0,  5, 7, 3'b000, 0, 1, 10, 32'hB0,      32'h00, 0, 0);
        add(0, 3'b000, 15'd0, 96'd0,                                                    1, 7,  5, 7, 3'b000, 1, 0, 0, 32'h0,        32'h00, 0, 0);
        add(0, 3'b010, {5'd0,5'd7,5'd0}, {32'h0,32'h77,32'h0},                          1, 7,  5, 7, 3'b010, 0, 0, 0, 32'h0,        32'h80, 0, 1);
        add(0, 3'b000, 15'd0, 96'd0,                                                    1, 7,  5, 7, 3'b000, 0, 1, 7, 32'h77,       32'h80, 0, 1);
        add(0, 3'b000, 15'd0, 96'd0,                                                    1, 7,  5, 7, 3'b000, 1, 0, 0, 32'h0,        32'h00, 0, 0);
        add(0, 3'b000, 15'd0, 96'd0,                                                    1, 0,  0, 7, 3'b000, 1, 0, 0, 32'h0,        32'h80, 0, 1);
        add(0, 3'b000, 15'd0, 96'd0,                                                    0, 0,  5, 7, 3'b000, 0, 0, 0, 32'h0,        32'h80, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            @(posedge clk);
            #1;
            rst           = vecs[i].rst;
            bus.req_valid = vecs[i].vld;
            bus.req_reg   = vecs[i].regs;
            bus.req_data  = vecs[i].data;
            bus.rsv_valid = vecs[i].rv;
            bus.rsv_reg   = vecs[i].rr;
            bus.chk_reg1  = vecs[i].c1;
            bus.chk_reg2  = vecs[i].c2;
            #3;
            check("req_ready", 32'(bus.req_ready), 32'(vecs[i].rdy));
            check("rsv_ok",    32'(bus.rsv_ok), 32'(vecs[i].ok));
            check("rf_we",     32'(bus.rf_write_enable), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check("rf_reg",  32'(bus.rf_write_reg), 32'(vecs[i].wreg));
                check("rf_data", bus.rf_write_data, vecs[i].wdata);
            end
            check("busy",      bus.busy, vecs[i].busy);
            check("chk_busy1", 32'(bus.chk_busy1), 32'(vecs[i].cb1));
            check("chk_busy2", 32'(bus.chk_busy2), 32'(vecs[i].cb2));
        end

        // Reset landing in the cycle a reserved write to r9 is committing.
        cur = 100;
        @(posedge clk);
        #1;
        drive_idle();
        bus.rsv_valid = 1'b1;
        bus.rsv_reg   = 5'd9;
        bus.chk_reg1  = 5'd9;
        #3;
        check("mid_rsv_ok", 32'(bus.rsv_ok), 32'd1);
        @(posedge clk);
        #1;
        bus.rsv_valid = 1'b0;
        bus.req_valid = 3'b001;
        bus.req_reg   = {5'd0, 5'd0, 5'd9};
        bus.req_data  = {32'h0, 32'h0, 32'h99999999};
        #3;
        check("mid_rdy",   32'(bus.req_ready), 32'd1);
        check("mid_busy9", 32'(bus.chk_busy1), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 3'b000;
        check("mid_we",   32'(bus.rf_write_enable), 32'd1);
        check("mid_reg",  32'(bus.rf_write_reg), 32'd9);
        check("mid_busy", bus.busy, 32'h280);
        rst = 1'b1;
        #1;
        check("rst_we",    32'(bus.rf_write_enable), 32'd0);
        check("rst_busy",  bus.busy, 32'd0);
        check("rst_busy9", 32'(bus.chk_busy1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_we",   32'(bus.rf_write_enable), 32'd0);
        check("post_busy", bus.busy, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back controller for the 32 x 32-bit register file. It shares the file's single synchronous write port between `NREQ` write-back sources (ALU, load unit, multiply/divide) using round-robin arbitration and a valid/ready handshake. It also maintains a per-register busy scoreboard that issue logic queries for RAW/WAW hazards. It sits between the execute/memory units and the register file's `write_enable`/`write_reg`/`write_data` inputs.

## Interface
- `NREQ`, 3: number of write-back requesters (2..8).
- `DATA_W`, 32: data width; must equal `` `WORD_SIZE ``.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  requester i holds a pending write.
- `req_reg`  in  5*NREQ  destination register of requester i (slice i).
- `req_data`  in  DATA_W*NREQ  write data of requester i (slice i).
- `req_ready`  out  NREQ  one-hot grant; transfer occurs on `req_valid[i] & req_ready[i]`.
- `rf_write_enable`  out  1  register-file write strobe (registered).
- `rf_write_reg`  out  5  register-file write address (registered).
- `rf_write_data`  out  DATA_W  register-file write data (registered).
- `rsv_valid`  in  1  issue logic reserves a destination register.
- `rsv_reg`  in  5  register being reserved.
- `rsv_ok`  out  1  combinational; reservation accepted this cycle.
- `chk_reg1`, `chk_reg2`  in  5 each  source registers to hazard-check.
- `chk_busy1`, `chk_busy2`  out  1 each  combinational busy bit of the checked register.
- `busy`  out  32  full scoreboard vector.

## Operation
- Arbitration: round-robin. Priority starts at the pointer `ptr`; the first i at or after `ptr` (mod NREQ) with `req_valid[i]` is granted.
- `req_ready` is combinational and depends on `req_valid`. It has at most one bit set and is zero when no request is valid.
- On a transfer from requester g: `ptr` becomes (g+1) mod NREQ. `ptr` is unchanged on idle cycles.
- Accepted write: on the next cycle, `rf_write_enable`=1, `rf_write_reg`=`req_reg[g]`, `rf_write_data`=`req_data[g]`.
- Register 0:
  - A request to r0 is accepted and consumes the grant and pointer advance.
  - `rf_write_enable` stays 0 for it.
- Scoreboard, set path:
  - `rsv_valid` with `busy[rsv_reg]`=0 and `rsv_reg`≠0: `rsv_ok`=1 and the bit is set at the edge.
  - `rsv_valid` with the bit already set: `rsv_ok`=0 and there is no state change. Issue logic stalls.
  - `rsv_reg`=0: `rsv_ok`=1 and nothing is set. `busy[0]` is constantly 0.
- Scoreboard, clear path: `busy[rf_write_reg]` is cleared at the edge that ends a cycle with `rf_write_enable`=1. This is the same edge at which the register file stores the data.
- Simultaneous clear and reserve of the same register in one cycle:
  - The reservation sees the pre-edge bit (1), so it is rejected.
  - The clear takes effect.
  - A retry one cycle later succeeds.
- A write to a register that is not busy (no reservation) is legal. It is written normally and the scoreboard is unchanged.

## Timing
- Reset (asynchronous, immediate):
  - `ptr`=0, `busy`=0, `rf_write_enable`=0, `rf_write_reg`=0, `rf_write_data`=0.
  - `req_ready`, `rsv_ok` and the `chk_busy*` outputs follow the cleared state combinationally.
- Write-back latency:
  - Handshake at edge T.
  - Register-file strobe is driven during cycle T+1.
  - Data is visible on the register file's read ports after edge T+1.
  - The busy bit is clear after edge T+1.
- Throughput: one write per cycle. Back-to-back grants to different requesters need no bubble.
- A requester must hold `req_valid`, `req_reg` and `req_data` stable until it sees `req_ready`.
- Reset asserted mid-operation: an in-flight registered write is dropped (`rf_write_enable` forced to 0) and all reservations are lost. Upstream units are reset together with this block.

## Structure
- Shared package/header holds:
  - `` `WORD_SIZE ``.
  - `REG_ADDR_W`=5.
  - `NUM_REGS`=32.
- Natural sub-module: `rr_arbiter` (parameter `N`). Inputs `clk`, `rst`, `req[N]`, `advance`; output one-hot `grant[N]`; it contains the pointer. It is reusable for the memory port.
- The scoreboard, output register and r0 masking stay in the top level.

## Test plan
- Reset then idle: `rst` pulse while all inputs are 0 → `rf_write_enable`=0, `busy`=0, `req_ready`=0.
- Single write: reserve r5 (`rsv_ok`=1, `busy[5]`=1 next cycle); requester 1 sends r5/0xDEADBEEF → `req_ready`=3'b010. Next cycle `rf_write_enable`=1, `rf_write_reg`=5, `rf_write_data`=0xDEADBEEF. After that edge, `busy[5]`=0.
- Round-robin fairness: all 3 requesters held valid for 6 cycles after reset → grant order 0,1,2,0,1,2.
- r0 write: requester 0 sends r0/0x1234 → grant given, `rf_write_enable` stays 0, `busy`=0, `ptr` advances to 1.
- WAW stall: r7 busy and `rsv_valid` for r7 → `rsv_ok`=0. In the cycle r7's write commits, a retry is still rejected; the retry one cycle later gets `rsv_ok`=1.
- Reset mid-write: assert `rst` during the cycle with `rf_write_enable`=1 for r9 → `rf_write_enable` drops immediately and `busy[9]`=0.
